// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline types and hazard-controller latch control words
package cpu_types_pkg;

    localparam int REGBITS = 5;

    typedef logic [REGBITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } hctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic fl_en;
        logic fl_flush;
        logic dl_en;
        logic dl_flush;
        logic el_en;
        logic el_flush;
        logic ml_en;
        logic ml_flush;
    } hctrl_t;

    // Field order: pc, fl en/flush, dl en/flush, el en/flush, ml en/flush
    localparam hctrl_t C_FREEZE = 9'b0_00_00_00_00;
    localparam hctrl_t C_HALT   = 9'b0_11_11_11_10;
    localparam hctrl_t C_REDIR  = 9'b1_11_11_11_10;
    localparam hctrl_t C_LU     = 9'b0_00_11_10_10;
    localparam hctrl_t C_MISS   = 9'b0_11_10_10_10;
    localparam hctrl_t C_RUN    = 9'b1_10_10_10_10;
    localparam hctrl_t C_DRAIN  = 9'b0_11_11_11_11;

endpackage

// File: rtl/hazard_ctrl_lu_hazard_detect.sv
// lu_hazard_detect: flags an ID-stage read of a register being loaded by the EX-stage instr
module lu_hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] dec_rsel1,
    input  logic [REG_W-1:0] dec_rsel2,
    input  logic             dec_uses_rt,
    output logic             lu_hazard
);

    assign lu_hazard = ex_dREN && (ex_wsel != '0) &&
                       ((ex_wsel == dec_rsel1) || (dec_uses_rt && (ex_wsel == dec_rsel2)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer driving latch en/flush, PC enable, halt drain and stall counter
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_halt,
    input  logic             redirect,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] dec_rsel1,
    input  logic [REG_W-1:0] dec_rsel2,
    input  logic             dec_uses_rt,
    output logic             pc_en,
    output logic             fl_en,
    output logic             fl_flush,
    output logic             dl_en,
    output logic             dl_flush,
    output logic             el_en,
    output logic             el_flush,
    output logic             ml_en,
    output logic             ml_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    hctrl_state_t state, next_state;
    hctrl_t       ctl;
    logic         mem_stall, lu_hazard;

    assign mem_stall = (mem_dREN | mem_dWEN) & ~dhit;

    lu_hazard_detect #(.REG_W(REG_W)) u_lu (
        .ex_dREN    (ex_dREN),
        .ex_wsel    (ex_wsel),
        .dec_rsel1  (dec_rsel1),
        .dec_rsel2  (dec_rsel2),
        .dec_uses_rt(dec_uses_rt),
        .lu_hazard  (lu_hazard)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state  <= next_state;
            halted <= next_state == HALTED;
            if (state == RUN && !ctl.pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // A frozen halt is not captured yet, so DRAIN starts only once dmem is done
    always_comb begin
        next_state = state == RUN ? ((!mem_stall && mem_halt) ? DRAIN : RUN) : HALTED;
    end

    always_comb begin
        ctl = RST              ? C_FREEZE :
              state == HALTED  ? C_FREEZE :
              state == DRAIN   ? C_DRAIN  :
              state != RUN     ? C_FREEZE :
              mem_stall        ? C_FREEZE :
              mem_halt         ? C_HALT   :
              redirect         ? C_REDIR  :
              lu_hazard        ? C_LU     :
              !ihit            ? C_MISS   : C_RUN;
    end

    assign {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush} = ctl;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl, with a 4-bit counter twin for saturation
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       ihit;
        logic       dhit;
        logic       dren;
        logic       dwen;
        logic       halt;
        logic       redir;
        logic       exr;
        logic [4:0] wsel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       urt;
    } stim_t;

    logic        CLK = 1'b0;
    stim_t       stim = '0;
    logic        pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush, halted;
    logic [15:0] stall_cnt;
    logic [8:0]  ctl4;
    logic        halted4;
    logic [3:0]  stall_cnt4;
    logic [29:0] obs;
    logic [29:0] expq[$];
    string       tagq[$];
    int          m_state = 0;
    logic [15:0] m_cnt = '0;
    logic [3:0]  m_cnt4 = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
        .CLK(CLK), .RST(stim.rst), .ihit(stim.ihit), .dhit(stim.dhit),
        .mem_dREN(stim.dren), .mem_dWEN(stim.dwen), .mem_halt(stim.halt), .redirect(stim.redir),
        .ex_dREN(stim.exr), .ex_wsel(stim.wsel), .dec_rsel1(stim.rs1), .dec_rsel2(stim.rs2),
        .dec_uses_rt(stim.urt),
        .pc_en(pc_en), .fl_en(fl_en), .fl_flush(fl_flush), .dl_en(dl_en), .dl_flush(dl_flush),
        .el_en(el_en), .el_flush(el_flush), .ml_en(ml_en), .ml_flush(ml_flush),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(4), .REG_W(5)) dut4 (
        .CLK(CLK), .RST(stim.rst), .ihit(stim.ihit), .dhit(stim.dhit),
        .mem_dREN(stim.dren), .mem_dWEN(stim.dwen), .mem_halt(stim.halt), .redirect(stim.redir),
        .ex_dREN(stim.exr), .ex_wsel(stim.wsel), .dec_rsel1(stim.rs1), .dec_rsel2(stim.rs2),
        .dec_uses_rt(stim.urt),
        .pc_en(ctl4[8]), .fl_en(ctl4[7]), .fl_flush(ctl4[6]), .dl_en(ctl4[5]), .dl_flush(ctl4[4]),
        .el_en(ctl4[3]), .el_flush(ctl4[2]), .ml_en(ctl4[1]), .ml_flush(ctl4[0]),
        .halted(halted4), .stall_cnt(stall_cnt4)
    );

    assign obs = {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush,
                  halted, stall_cnt, stall_cnt4};

    function automatic stim_t st(logic rst, logic ihit, logic dhit, logic dren, logic dwen, logic halt,
                                 logic redir, logic exr, int wsel, int rs1, int rs2, logic urt);
        return '{rst, ihit, dhit, dren, dwen, halt, redir, exr, 5'(wsel), 5'(rs1), 5'(rs2), urt};
    endfunction

    // Reference control word: {pc, fl en/fl, dl en/fl, el en/fl, ml en/fl}
    function automatic logic [8:0] model(stim_t s, int sst);
        logic ms, lu;
        ms = (s.dren || s.dwen) && !s.dhit;
        lu = s.exr && s.wsel != 0 && (s.wsel == s.rs1 || (s.urt && s.wsel == s.rs2));
        if (s.rst || sst == 2) return 9'b000000000;
        if (sst == 1) return 9'b011111111;
        if (ms) return 9'b000000000;
        if (s.halt) return 9'b011111110;
        if (s.redir) return 9'b111111110;
        if (lu) return 9'b000111010;
        if (!s.ihit) return 9'b011101010;
        return 9'b110101010;
    endfunction

    always @(posedge CLK) begin
        if (stim.rst) begin
            m_state <= 0;
            m_cnt   <= '0;
            m_cnt4  <= '0;
        end else if (m_state == 0) begin
            if (model(stim, 0) < 9'h100) begin
                if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
                if (m_cnt4 != 4'hF) m_cnt4 <= m_cnt4 + 4'd1;
            end
            if (stim.halt && !((stim.dren || stim.dwen) && !stim.dhit)) m_state <= 1;
        end else begin
            m_state <= 2;
        end
    end

    task automatic drive(stim_t s, string tag);
        stim = s;
        expq.push_back({model(s, m_state), m_state == 2, m_cnt, m_cnt4});
        tagq.push_back(tag);
    endtask

    task automatic test_reset();
        stim_t rows[$];
        logic [29:0] e;
        string t;
        rows = '{st(1,1,0,1,1,1,1,1,8,8,8,1), st(1,0,1,0,0,0,1,0,0,0,0,0), st(0,1,1,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i], $sformatf("reset[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t rows[$];
        logic [29:0] e;
        string t;
        rows = '{st(1,1,1,0,0,0,0,0,0,0,0,0), st(0,1,1,0,0,0,0,1,8,8,0,0),
                 st(0,1,1,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i], $sformatf("load_use[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_no_stall();
        stim_t rows[$];
        logic [29:0] e;
        string t;
        rows = '{st(1,1,1,0,0,0,0,0,0,0,0,0), st(0,1,1,0,0,0,0,1,0,0,0,1),
                 st(0,1,1,0,0,0,0,1,9,3,9,0), st(0,1,1,0,0,0,0,1,9,3,9,1),
                 st(0,1,1,0,0,0,0,0,9,9,9,1)};
        foreach (rows[i]) begin
            drive(rows[i], $sformatf("no_stall[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_mem_stall();
        stim_t rows[$];
        logic [29:0] e;
        string t;
        rows = '{st(1,1,1,0,0,0,0,0,0,0,0,0), st(0,1,0,1,0,0,0,0,0,0,0,0),
                 st(0,1,0,1,0,0,0,0,0,0,0,0), st(0,1,0,1,0,0,0,0,0,0,0,0),
                 st(0,1,1,1,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i], $sformatf("mem_stall[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
        checks++;
        if (stall_cnt !== 16'd3) begin errors++; $display("FAIL mem_stall_cnt: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_redirect();
        stim_t rows[$];
        logic [29:0] e;
        string t;
        rows = '{st(1,1,1,0,0,0,0,0,0,0,0,0), st(0,0,1,0,0,0,1,1,8,8,0,0),
                 st(0,1,1,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i], $sformatf("redirect[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL redirect_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_halt();
        stim_t rows[$];
        logic [29:0] e;
        string t;
        rows = '{st(1,1,1,0,0,0,0,0,0,0,0,0), st(0,1,1,0,0,1,0,0,0,0,0,0),
                 st(0,1,1,0,0,0,1,0,0,0,0,0), st(0,1,1,0,0,0,1,0,0,0,0,0),
                 st(0,1,1,0,0,1,1,1,8,8,0,0), st(0,0,0,1,1,1,0,0,0,0,0,0),
                 st(1,1,1,0,0,0,0,0,0,0,0,0), st(0,1,1,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i], $sformatf("halt[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
        checks++;
        if (halted !== 1'b0 || stall_cnt !== 16'd0)
            begin errors++; $display("FAIL halt_exit: got h=%b c=%0d want h=0 c=0", halted, stall_cnt); end
    endtask

    task automatic test_back_to_back();
        stim_t rows[$];
        logic [29:0] e;
        string t;
        rows = '{st(1,1,1,0,0,0,0,0,0,0,0,0), st(0,1,0,1,0,0,1,0,0,0,0,0),
                 st(0,0,0,0,1,1,1,0,0,0,0,0), st(0,1,1,0,1,0,1,1,3,3,0,0),
                 st(0,1,0,1,0,1,0,0,0,0,0,0), st(0,1,1,1,0,1,0,0,0,0,0,0),
                 st(0,1,1,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i], $sformatf("b2b[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_saturation();
        logic [29:0] e;
        string t;
        for (int i = 0; i < 21; i++) begin
            drive(i == 0 ? st(1,1,1,0,0,0,0,0,0,0,0,0) : st(0,0,1,0,0,0,0,0,0,0,0,0),
                  $sformatf("sat[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
        checks++;
        if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20)
            begin errors++; $display("FAIL sat_cnt: got %0d/%0d want 15/20", stall_cnt4, stall_cnt); end
    endtask

    task automatic test_random();
        logic [29:0] e;
        string t;
        stim_t s;
        for (int i = 0; i < 300; i++) begin
            s = st($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(3) == 0,
                   $urandom_range(5) == 0, $urandom_range(19) == 0, $urandom_range(5) == 0, $urandom_range(1),
                   $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(1));
            drive(s, $sformatf("rand[%0d]", i));
            @(negedge CLK);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h want %h", t, obs, e); end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        stim = st(1,1,1,0,0,0,0,0,0,0,0,0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_mem_stall();
        test_redirect();
        test_halt();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. Drives the en/flush pair of every inter-stage latch (fetch, decode, execute, memory) and the PC enable. Resolves load-use stalls, dmem waits, imem misses, control redirects and halt drain. Keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 16, width of stall_cnt
REG_W, 5, register-select width (matches regbits_t)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
ihit  in  1  imem returned the instruction this cycle
dhit  in  1  dmem access completed this cycle
mem_dREN  in  1  instr in MEM stage reads dmem
mem_dWEN  in  1  instr in MEM stage writes dmem
mem_halt  in  1  halt instr in MEM stage
redirect  in  1  taken branch/jump resolved in MEM stage
ex_dREN  in  1  instr in EX stage is a load
ex_wsel  in  REG_W  EX-stage destination register
dec_rsel1  in  REG_W  ID-stage source rs
dec_rsel2  in  REG_W  ID-stage source rt
dec_uses_rt  in  1  ID instr actually reads rt
pc_en  out  1  PC register update enable
fl_en, fl_flush  out  1,1  fetch latch controls
dl_en, dl_flush  out  1,1  decode latch controls
el_en, el_flush  out  1,1  execute latch controls
ml_en, ml_flush  out  1,1  memory latch controls
halted  out  1  core halted (sticky)
stall_cnt  out  CNT_W  RUN cycles with pc_en=0, saturating

Behaviour:
- Latch semantics: flush acts only with en=1; en=0 holds the latch.
- States: RUN, DRAIN, HALTED. Registered: state, halted, stall_cnt. All en/flush/pc_en are combinational from state and inputs.
- RST=1 (synchronous): next state RUN, halted<=0, stall_cnt<=0. While RST=1 all en, flush and pc_en are 0.
- Derived terms:
  - mem_stall = (mem_dREN|mem_dWEN) & !dhit
  - lu_hazard = ex_dREN & ex_wsel!=0 & (ex_wsel==dec_rsel1 | (dec_uses_rt & ex_wsel==dec_rsel2))
- RUN priority, first match wins:
  1. mem_stall: every en=0, every flush=0, pc_en=0. Whole pipe frozen.
  2. mem_halt: pc_en=0. fl/dl/el en=1 flush=1. ml_en=1 ml_flush=0, capturing the halt. Next state DRAIN.
  3. redirect: pc_en=1 regardless of ihit. fl/dl/el en=1 flush=1. ml_en=1 ml_flush=0.
  4. lu_hazard: pc_en=0, fl_en=0 (hold). dl_en=1 dl_flush=1 (bubble). el_en=ml_en=1, no flush.
  5. !ihit: pc_en=0. fl_en=1 fl_flush=1 (bubble). dl/el/ml en=1, no flush.
  6. Otherwise: pc_en=1, all en=1, all flush=0.
- DRAIN (exactly 1 cycle):
  - pc_en=0; all four latches en=1 flush=1.
  - The halt in the memory latch advances to WB this cycle.
  - Next state HALTED, halted<=1.
- HALTED: all en=0, flush=0, pc_en=0, halted=1. All inputs ignored. Exit only via RST.
- stall_cnt: increments by 1 on each RUN cycle with pc_en=0 (cases 1, 2, 4, 5). Holds at 2^CNT_W-1. Never counts in DRAIN, HALTED or during RST.
- Boundaries:
  - Register 0 never causes a load-use stall.
  - redirect with lu_hazard or !ihit: redirect wins.
  - mem_stall with redirect/halt: freeze wins; the redirect/halt is re-evaluated each cycle until dhit.
  - RST asserted in DRAIN or HALTED: returns to RUN next cycle.

Decomposition:
- cpu_types_pkg: hctrl_state_t enum {RUN, DRAIN, HALTED}; reuse regbits_t for REG_W fields.
- One natural sub-module, lu_hazard_detect: combinational load-use compare producing lu_hazard. Unit-testable separately.

Test Plan:
1. ex_dREN=1, ex_wsel=8, dec_rsel1=8, ihit=1 -> pc_en=0, fl_en=0, dl_en=1, dl_flush=1, el_en=ml_en=1; stall_cnt 0->1.
2. ex_dREN=1, ex_wsel=0, dec_rsel1=0 -> no stall: all en=1, pc_en=1, stall_cnt unchanged. Also ex_wsel=9, dec_rsel2=9, dec_uses_rt=0 -> no stall.
3. mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> all en=0 for 3 cycles, stall_cnt +3; 4th cycle all en=1, pc_en=1.
4. redirect=1 with lu_hazard=1 and ihit=0 -> pc_en=1; fl/dl/el en=1 flush=1; ml_en=1, ml_flush=0; stall_cnt unchanged.
5. mem_halt=1, dhit=1 -> cycle0 ml_en=1, fl/dl/el flush=1; cycle1 DRAIN, all flush=1; cycle2+ halted=1, all en=0 regardless of ihit/redirect; RST=1 for one cycle -> RUN, halted=0, stall_cnt=0.
6. CNT_W=4, ihit=0 held 20 cycles -> stall_cnt reaches 15 and holds at 15.
